// File: rtl/typed_trunc_accum_if.sv
// Beat/result handshake bundle for typed_trunc_accum: two 32-bit lanes in, batch result out.
interface typed_trunc_accum_if #(parameter int ACC_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [3:0]       out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, clear, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_ovf
    );
endinterface

// File: rtl/typed_trunc_accum.sv
// Narrows two 32-bit lanes through typedef-returning functions and sums them over a batch of beats,
// emitting one registered result (sum, beat count, wrap flag) per batch or per early flush.
package P;
    typedef logic [3:0] S;
endpackage

typedef logic [1:0] T;

// state | meaning
// ACC   | accepting beats into acc/cnt/ovf
// OUT   | result held on the output register until out_ready
module typed_trunc_accum #(
    parameter int ACC_W = 8,
    parameter int BATCH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    typed_trunc_accum_if.slave bus
);
    typedef enum logic {ACC, OUT} state_t;

    localparam logic [3:0] BATCH_C = 4'(BATCH);

    function automatic T trunc_t(input logic [31:0] w);
        return T'(w);
    endfunction

    function automatic P::S trunc_s(input logic [31:0] w);
        return P::S'(w);
    endfunction

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [3:0]       out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;

    logic             in_ready;
    logic             active;
    logic             take;
    logic [4:0]       term;
    logic [ACC_W-1:0] base;
    logic [3:0]       base_cnt;
    logic             base_ovf;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] p_acc;
    logic [3:0]       p_cnt;
    logic             p_ovf;
    logic             flush;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;

        active   = (state_q == ACC) || bus.out_ready;
        in_ready = active;
        take     = bus.in_valid && in_ready;

        term = {3'b000, trunc_t(bus.in_a)} + {1'b0, trunc_s(bus.in_b)};

        // Leaving OUT starts a fresh batch, so the base is zero there.
        base     = (state_q == ACC) ? acc_q : '0;
        base_cnt = (state_q == ACC) ? cnt_q : 4'd0;
        base_ovf = (state_q == ACC) ? ovf_q : 1'b0;

        sum   = {1'b0, base} + {{(ACC_W-4){1'b0}}, term};
        p_acc = take ? sum[ACC_W-1:0] : base;
        p_cnt = take ? base_cnt + 4'd1 : base_cnt;
        p_ovf = take ? (base_ovf | sum[ACC_W]) : base_ovf;

        flush = (p_cnt == BATCH_C) || (bus.clear && state_q == ACC && p_cnt != 4'd0);

        if (active) begin
            if (flush) begin
                out_valid_d = 1'b1;
                out_sum_d   = p_acc;
                out_cnt_d   = p_cnt;
                out_ovf_d   = p_ovf;
                acc_d       = '0;
                cnt_d       = 4'd0;
                ovf_d       = 1'b0;
                state_d     = OUT;
            end else begin
                out_valid_d = 1'b0;
                acc_d       = p_acc;
                cnt_d       = p_cnt;
                ovf_d       = p_ovf;
                state_d     = ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= 4'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= 4'd0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_typed_trunc_accum.sv
// Bench for typed_trunc_accum: a BATCH=4 and a BATCH=15 instance checked every cycle against a
// batch-total model, plus literal expectations for the directed scenarios.
module tb_typed_trunc_accum;
    localparam int ACC_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typed_trunc_accum_if #(.ACC_W(ACC_W)) if4  ();
    typed_trunc_accum_if #(.ACC_W(ACC_W)) if15 ();

    typed_trunc_accum #(.ACC_W(ACC_W), .BATCH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    typed_trunc_accum #(.ACC_W(ACC_W), .BATCH(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(if15.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: exact running total of the open batch; the result is derived from it when the batch closes.
    bit m_valid [2] = '{0, 0};
    int m_sum   [2] = '{0, 0};
    int m_cnt   [2] = '{0, 0};
    bit m_ovf   [2] = '{0, 0};
    int m_tot   [2] = '{0, 0};
    int m_n     [2] = '{0, 0};
    int batch_of[2] = '{4, 15};

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit iv, input logic [31:0] a, input logic [31:0] b,
                              input bit clr, input bit ordy);
        bit was;
        bit rdy;
        was = m_valid[k];
        rdy = !was || ordy;
        if (was && ordy) m_valid[k] = 0;
        if (iv && rdy) begin
            m_tot[k] += int'(a % 4) + int'(b % 16);
            m_n[k]++;
        end
        if (rdy && (m_n[k] == batch_of[k] || (clr && !was && m_n[k] > 0))) begin
            m_valid[k] = 1;
            m_sum[k]   = m_tot[k] % (1 << ACC_W);
            m_ovf[k]   = (m_tot[k] >= (1 << ACC_W));
            m_cnt[k]   = m_n[k];
            m_tot[k]   = 0;
            m_n[k]     = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_tot[k] = 0; m_n[k] = 0;
            end
        end else begin
            model_step(0, if4.in_valid, if4.in_a, if4.in_b, if4.clear, if4.out_ready);
            model_step(1, if15.in_valid, if15.in_a, if15.in_b, if15.clear, if15.out_ready);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("b4.in_ready",  if4.in_ready,  (!m_valid[0] || if4.out_ready));
            chk("b4.out_valid", if4.out_valid, m_valid[0]);
            if (m_valid[0]) begin
                chk("b4.out_sum", if4.out_sum, m_sum[0]);
                chk("b4.out_cnt", if4.out_cnt, m_cnt[0]);
                chk("b4.out_ovf", if4.out_ovf, m_ovf[0]);
            end
            chk("b15.in_ready",  if15.in_ready,  (!m_valid[1] || if15.out_ready));
            chk("b15.out_valid", if15.out_valid, m_valid[1]);
            if (m_valid[1]) begin
                chk("b15.out_sum", if15.out_sum, m_sum[1]);
                chk("b15.out_cnt", if15.out_cnt, m_cnt[1]);
                chk("b15.out_ovf", if15.out_ovf, m_ovf[1]);
            end
        end
    end

    // One clock of stimulus on instance k; valid and clear last a single cycle.
    task automatic drive(input int k, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input bit clr, input bit ordy);
        if (k == 0) begin
            if4.in_valid = v; if4.in_a = a; if4.in_b = b; if4.clear = clr; if4.out_ready = ordy;
        end else begin
            if15.in_valid = v; if15.in_a = a; if15.in_b = b; if15.clear = clr; if15.out_ready = ordy;
        end
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;  if4.clear = 1'b0;
        if15.in_valid = 1'b0; if15.clear = 1'b0;
    endtask

    task automatic chk_res4(input string nm, input int s, input int c, input int o);
        chk({nm, ".valid"}, if4.out_valid, 1);
        chk({nm, ".sum"},   if4.out_sum, s);
        chk({nm, ".cnt"},   if4.out_cnt, c);
        chk({nm, ".ovf"},   if4.out_ovf, o);
    endtask

    initial begin
        if4.in_valid = 0;  if4.in_a = 0;  if4.in_b = 0;  if4.clear = 0;  if4.out_ready = 1;
        if15.in_valid = 0; if15.in_a = 0; if15.in_b = 0; if15.clear = 0; if15.out_ready = 1;

        #12;
        chk("reset.out_valid", if4.out_valid, 0);
        chk("reset.out_sum",   if4.out_sum, 0);
        chk("reset.out_cnt",   if4.out_cnt, 0);
        chk("reset.in_ready",  if4.in_ready, 1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full batch: 1 + 3 per beat
        repeat (4) drive(0, 1, 32'h0000_0001, 32'hFFFF_FFF3, 0, 1);
        chk_res4("full", 16, 4, 0);

        // Truncation, back-to-back with the previous result being taken
        repeat (4) drive(0, 1, 32'hFFFF_FFFF, 32'h0000_0010, 0, 1);
        chk_res4("trunc", 12, 4, 0);

        // Overflow on the BATCH=15 instance: 15 * 18 = 270
        repeat (15) drive(1, 1, 32'd3, 32'd15, 0, 1);
        chk("ovf.valid", if15.out_valid, 1);
        chk("ovf.sum",   if15.out_sum, 14);
        chk("ovf.cnt",   if15.out_cnt, 15);
        chk("ovf.ovf",   if15.out_ovf, 1);

        // Backpressure: result of 4 held while out_ready=0
        repeat (4) drive(0, 1, 32'd1, 32'd0, 0, 0);
        chk_res4("bp.load", 4, 4, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'd3, 32'd15, 1, 0);
            chk("bp.in_ready", if4.in_ready, 0);
            chk_res4("bp.hold", 4, 4, 0);
        end
        drive(0, 1, 32'd1, 32'd1, 0, 1);
        chk("bp.taken", if4.out_valid, 0);
        repeat (3) drive(0, 1, 32'd1, 32'd0, 0, 1);
        chk_res4("bp.next", 5, 4, 0);

        // Partial flush: 4 + 4 + 5 with clear on the last beat
        repeat (2) drive(0, 1, 32'd0, 32'd4, 0, 1);
        drive(0, 1, 32'd1, 32'd4, 1, 1);
        chk_res4("flush", 13, 3, 0);
        drive(0, 0, 32'd0, 32'd0, 1, 1);
        chk("flush.taken", if4.out_valid, 0);
        drive(0, 0, 32'd0, 32'd0, 1, 1);
        chk("flush.empty", if4.out_valid, 0);

        // Async reset mid-batch, between clock edges
        repeat (2) drive(0, 1, 32'd1, 32'd0, 0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", if4.out_valid, 0);
        chk("arst.out_sum",   if4.out_sum, 0);
        chk("arst.out_cnt",   if4.out_cnt, 0);
        chk("arst.out_ovf",   if4.out_ovf, 0);
        #1 rst_n = 1'b1;
        repeat (4) drive(0, 1, 32'd1, 32'd0, 0, 1);
        chk_res4("arst.next", 4, 4, 0);

        repeat (3) drive(0, 0, 32'd0, 32'd0, 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/typed_trunc_accum.md
Name: typed_trunc_accum

Overview:
- Consumer stage for the 32-bit words produced by the typedef-returning function stage (one word on each of two lanes per beat).
- Narrows each lane through automatic functions whose return types are typedefs:
  - lane A uses compilation-unit typedef T = logic [1:0];
  - lane B uses package typedef P::S = logic [3:0].
- Accumulates the zero-extended narrowed values over a batch of beats.
- Emits one registered batch result per batch, with valid/ready handshakes on both sides.

Parameters:
- ACC_W, 8, accumulator and out_sum width; legal range 6..32.
- BATCH, 4, beats per full batch; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_a  input  32  lane A word; only bits [1:0] are used, via function returning T.
- in_b  input  32  lane B word; only bits [3:0] are used, via function returning P::S.
- clear  input  1  synchronous flush request.
- out_valid  output  1  batch result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  batch sum, modulo 2^ACC_W.
- out_cnt  output  4  number of beats in the result.
- out_ovf  output  1  accumulator wrapped at least once during the batch.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACC; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
  - A reset mid-batch or while a result is pending discards everything; no result is emitted.
- Narrowing:
  - trunc_t(in_a) returns T and trunc_s(in_b) returns P::S; both truncate implicitly and are unsigned.
  - term = zero-extended trunc_t + zero-extended trunc_s; range 0..18, computed 5 bits wide.
- States:
  - ACC: accepting beats.
  - OUT: result held on the output register.
- in_ready = (state==ACC) || (state==OUT && out_ready). It is combinational and never depends on in_valid.
- Beat accepted (in ACC, or in OUT in the same cycle the result is taken):
  - sum = base + term, computed ACC_W+1 bits wide.
  - base is acc in ACC, and 0 when coming from OUT.
  - ovf_n = base_ovf | carry out of sum; n = base_cnt + 1.
  - If n==BATCH: load out_sum=sum[ACC_W-1:0], out_cnt=n, out_ovf=ovf_n; set out_valid=1; go to OUT; clear acc/cnt/ovf.
  - Otherwise: acc=sum[ACC_W-1:0], cnt=n, ovf=ovf_n; stay in (or return to) ACC.
- Latency: the result is visible on the cycle after the final beat is accepted. Throughput is one beat per cycle, with no bubble when out_ready stays high.
- Result handshake:
  - In OUT with out_ready=1, the result is consumed and out_valid drops next cycle unless a new result is loaded in the same cycle (possible only when BATCH==1).
  - In OUT with out_ready=0, all outputs hold stable and in_ready=0.
- clear, when in ACC:
  - A beat accepted in the same cycle is included first.
  - If the resulting count is >0, a partial result is emitted exactly as a full batch would be, with out_cnt = that count.
  - If the count is 0, clear is a no-op.
- clear in OUT is ignored; the pending result is neither dropped nor altered.
- out_cnt is never 0 while out_valid=1.

Test Plan:
- Full batch: BATCH=4; 4 beats with in_a=32'h0000_0001, in_b=32'hFFFF_FFF3 (narrow to 1 and 3) -> one cycle after the 4th beat, out_valid=1, out_sum=16, out_cnt=4, out_ovf=0.
- Truncation: 4 beats with in_a=32'hFFFF_FFFF, in_b=32'h0000_0010 -> out_sum=12 (3+0 per beat), out_cnt=4.
- Overflow: ACC_W=8, BATCH=15; 15 beats with in_a=3, in_b=15 -> out_sum=14 (270 mod 256), out_ovf=1.
- Backpressure:
  - A result is pending and out_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout.
  - Then out_ready=1 together with in_valid=1 (in_a=1, in_b=1) -> result consumed, and the new batch starts with acc=2, cnt=1, in the same cycle.
- Partial flush: 2 beats of term 4, then clear together with a beat of term 5 -> out_sum=13, out_cnt=3; clear with cnt=0 and no beat -> no result.
- Async reset: rst_n pulsed low mid-batch (cnt=2) with no clock edge -> all outputs 0 immediately; the next 4 beats of term 1 produce out_sum=4.
